// File: rtl/lights_press_engine.sv
// rtl/lights_press_engine.sv - cross press / single toggle read-modify-write engine with board-dark scan
//
// Purpose: on an accepted start, toggles the pressed cell (and, for a cross
// press, its four neighbours) in a row-per-word board RAM, then reads every
// row back to report whether the whole board is dark.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   start             one-cycle request, sampled only when idle
//   mode              0 = cross press, 1 = single-cell toggle
//   sel_x, sel_y      pressed column / row, captured on accepted start
//   clear_count       synchronous clear of press_count (wins over increment)
//   ram_addr          registered board RAM row address
//   ram_wdata         registered board RAM write data
//   ram_wren          registered board RAM write enable
//   ram_rdata         board RAM read data, valid the cycle after ram_addr changes
//   busy              high from the cycle after an accepted start until done
//   done              one-cycle completion pulse
//   err               one-cycle pulse with done for out-of-range coordinates
//   row_wr            renderer redraw strobe, coincident with ram_wren
//   board_zero        result of the last completed scan (1 = all cells dark)
//   press_count       saturating count of completed in-range presses
module lights_press_engine #(
  parameter int COLS  = 32,
  parameter int ROWS  = 32,
  parameter int ROW_W = 5,
  parameter int COL_W = 5,
  parameter int WRAP  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [COL_W-1:0] sel_x,
  input  logic [ROW_W-1:0] sel_y,
  input  logic             clear_count,
  output logic [ROW_W-1:0] ram_addr,
  output logic [COLS-1:0]  ram_wdata,
  output logic             ram_wren,
  input  logic [COLS-1:0]  ram_rdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             row_wr,
  output logic             board_zero,
  output logic [15:0]      press_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WAIT, S_WR, S_SKIP, S_SCAN, S_DONE
  } state_t;

  localparam logic [1:0] P_ABOVE = 2'd0;
  localparam logic [1:0] P_MID   = 2'd1;
  localparam logic [1:0] P_BELOW = 2'd2;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W:0]   SCAN_END = (ROW_W+1)'(ROWS);
  localparam logic [COLS-1:0]  ONE      = COLS'(1);

  state_t           state, state_n;
  logic [1:0]       phase, phase_n;
  logic [COL_W-1:0] x_r, x_n;
  logic [ROW_W-1:0] y_r, y_n;
  logic             mode_r, mode_n;
  logic [ROW_W:0]   scan_cnt, scan_n, scan_inc;
  logic             acc, acc_n, acc_or;
  logic [ROW_W-1:0] addr_n;
  logic [COLS-1:0]  wdata_n;
  logic             wren_n, err_n, zero_n, go;
  logic [15:0]      count_n;

  logic [1:0]       enter_phase;
  logic [ROW_W-1:0] cur_y, enter_addr;
  logic             skip_row, x_bad, y_bad;
  logic [COLS-1:0]  mask;

  // Row about to be entered: the first row of a new press (using the live
  // inputs, since they are only captured at the same edge) or the next row.
  always_comb begin
    cur_y       = (state == S_IDLE) ? sel_y : y_r;
    enter_phase = (state == S_IDLE) ? (mode ? P_MID : P_ABOVE) : (phase + 2'd1);
    skip_row    = 1'b0;
    enter_addr  = cur_y;
    if (enter_phase == P_ABOVE) begin
      enter_addr = (cur_y == '0) ? ROW_LAST : (cur_y - ROW_W'(1));
      skip_row   = (WRAP == 0) && (cur_y == '0);
    end else if (enter_phase == P_BELOW) begin
      enter_addr = (cur_y == ROW_LAST) ? '0 : (cur_y + ROW_W'(1));
      skip_row   = (WRAP == 0) && (cur_y == ROW_LAST);
    end
  end

  // Toggle mask for the row currently in flight.
  always_comb begin
    mask = ONE << x_r;
    if (phase == P_MID && !mode_r) begin
      if (x_r != '0)
        mask = mask | (ONE << (x_r - COL_W'(1)));
      else if (WRAP != 0)
        mask = mask | (ONE << COL_LAST);
      if (x_r != COL_LAST)
        mask = mask | (ONE << (x_r + COL_W'(1)));
      else if (WRAP != 0)
        mask = mask | ONE;
    end
  end

  assign x_bad    = ({1'b0, sel_x} >= (COL_W+1)'(COLS));
  assign y_bad    = ({1'b0, sel_y} >= (ROW_W+1)'(ROWS));
  assign acc_or   = acc | (|ram_rdata);
  assign scan_inc = scan_cnt + (ROW_W+1)'(1);

  always_comb begin
    state_n = state;
    phase_n = phase;
    x_n     = x_r;
    y_n     = y_r;
    mode_n  = mode_r;
    scan_n  = scan_cnt;
    acc_n   = acc;
    addr_n  = ram_addr;
    wdata_n = ram_wdata;
    wren_n  = 1'b0;
    err_n   = 1'b0;
    zero_n  = board_zero;
    count_n = press_count;
    go      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          x_n    = sel_x;
          y_n    = sel_y;
          mode_n = mode;
          if (x_bad || y_bad) begin
            state_n = S_DONE;
            err_n   = 1'b1;
          end else begin
            go = 1'b1;
          end
        end
      end
      S_RD:   state_n = S_WAIT;
      S_WAIT: begin
        state_n = S_WR;
        wren_n  = 1'b1;
        wdata_n = ram_rdata ^ mask;
      end
      S_WR, S_SKIP: begin
        if (phase == P_BELOW || mode_r) begin
          state_n = S_SCAN;
          scan_n  = '0;
          acc_n   = 1'b0;
          addr_n  = '0;
        end else begin
          go = 1'b1;
        end
      end
      S_SCAN: begin
        // Data seen in scan cycle k belongs to row k-1; cycle 0 has none.
        if (scan_cnt != '0)
          acc_n = acc_or;
        if (scan_cnt == SCAN_END) begin
          zero_n  = !acc_or;
          state_n = S_DONE;
        end else begin
          scan_n = scan_inc;
          if (scan_inc < SCAN_END)
            addr_n = scan_inc[ROW_W-1:0];
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        if (!err && press_count != 16'hFFFF)
          count_n = press_count + 16'd1;
      end
      default: state_n = S_IDLE;
    endcase
    if (go) begin
      phase_n = enter_phase;
      if (skip_row) begin
        state_n = S_SKIP;
      end else begin
        state_n = S_RD;
        addr_n  = enter_addr;
      end
    end
    if (clear_count)
      count_n = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      phase       <= P_ABOVE;
      x_r         <= '0;
      y_r         <= '0;
      mode_r      <= 1'b0;
      scan_cnt    <= '0;
      acc         <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_wren    <= 1'b0;
      row_wr      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      board_zero  <= 1'b0;
      press_count <= '0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      x_r         <= x_n;
      y_r         <= y_n;
      mode_r      <= mode_n;
      scan_cnt    <= scan_n;
      acc         <= acc_n;
      ram_addr    <= addr_n;
      ram_wdata   <= wdata_n;
      ram_wren    <= wren_n;
      row_wr      <= wren_n;
      busy        <= (state_n != S_IDLE) && (state_n != S_DONE);
      done        <= (state_n == S_DONE);
      err         <= err_n;
      board_zero  <= zero_n;
      press_count <= count_n;
    end
  end

endmodule
